// File: rtl/counter24_pkg.sv
// Shared constants for the BCD counter and its multiplexed 7-segment display.
package counter24_pkg;

    // Largest legal value of a single BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-high segment patterns {dp,g,f,e,d,c,b,a}; dp is never lit.
    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_DASH = 8'h40;

    // Active-low digit enables: bit 0 drives the ones digit, bit 1 the tens digit.
    typedef enum logic [1:0] {
        DIG_ONES = 2'b10,
        DIG_TENS = 2'b01
    } dig_sel_e;

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD digit to 7-segment pattern decoder; non-BCD codes show a dash.
module bcd7seg
    import counter24_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/counter24_bcd_scan.sv
// Modulo-MOD BCD up/down counter advanced by rising edges of a slow divided
// clock (sampled as data), with a two-digit multiplexed 7-segment display.
module counter24_bcd_scan
    import counter24_pkg::*;
#(
    parameter int MOD      = 24,
    parameter int SCAN_DIV = 12000,
    parameter int SCAN_W   = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       run,
    input  logic       up_dn,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry,
    output logic       load_err,
    output logic [7:0] seg,
    output logic [1:0] dig_sel
);

    localparam logic [3:0]        MAX_TENS  = 4'((MOD - 1) / 10);
    localparam logic [3:0]        MAX_ONES  = 4'((MOD - 1) % 10);
    localparam logic [7:0]        MOD_B     = 8'(MOD);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // Synchroniser chain for tick_in; vld_pN marks that tick_pN holds a sample
    // taken after reset release, so a level already high at release is no edge.
    logic tick_p0, tick_p1, tick_p2;
    logic vld_p0, vld_p1, vld_p2;
    logic tick;

    logic [3:0] tens_nxt, ones_nxt;
    logic       carry_nxt, load_err_nxt;
    logic       at_max, at_zero;
    logic [3:0] ld_tens, ld_ones;
    logic [7:0] ld_bin;
    logic       load_ok;

    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_wrap;
    dig_sel_e          dig_r, dig_nxt;
    logic [3:0]        seg_digit;
    logic [7:0]        seg_dec;

    // Two-flop synchroniser plus edge-history register, with sample-valid shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_p0 <= 1'b0;
            tick_p1 <= 1'b0;
            tick_p2 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            tick_p0 <= tick_in;
            tick_p1 <= tick_p0;
            tick_p2 <= tick_p1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
        end
    end

    assign tick = tick_p1 & ~tick_p2 & vld_p2;

    assign at_max  = (tens == MAX_TENS) && (ones == MAX_ONES);
    assign at_zero = (tens == 4'd0) && (ones == 4'd0);

    assign ld_tens = load_val[7:4];
    assign ld_ones = load_val[3:0];
    assign ld_bin  = ({4'd0, ld_tens} * 8'd10) + {4'd0, ld_ones};
    assign load_ok = (ld_tens <= BCD_MAX) && (ld_ones <= BCD_MAX) && (ld_bin < MOD_B);

    // Next counter value: clear beats load, load beats a counting tick.
    always_comb begin
        tens_nxt     = tens;
        ones_nxt     = ones;
        carry_nxt    = 1'b0;
        load_err_nxt = 1'b0;
        if (clr) begin
            tens_nxt = 4'd0;
            ones_nxt = 4'd0;
        end else if (load) begin
            if (load_ok) begin
                tens_nxt = ld_tens;
                ones_nxt = ld_ones;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (tick && run) begin
            if (up_dn) begin
                if (at_max) begin
                    tens_nxt  = 4'd0;
                    ones_nxt  = 4'd0;
                    carry_nxt = 1'b1;
                end else if (ones == BCD_MAX) begin
                    ones_nxt = 4'd0;
                    tens_nxt = tens + 4'd1;
                end else begin
                    ones_nxt = ones + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    tens_nxt  = MAX_TENS;
                    ones_nxt  = MAX_ONES;
                    carry_nxt = 1'b1;
                end else if (ones == 4'd0) begin
                    ones_nxt = BCD_MAX;
                    tens_nxt = tens - 4'd1;
                end else begin
                    ones_nxt = ones - 4'd1;
                end
            end
        end
    end

    // Counter digits and the single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens     <= 4'd0;
            ones     <= 4'd0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tens     <= tens_nxt;
            ones     <= ones_nxt;
            carry    <= carry_nxt;
            load_err <= load_err_nxt;
        end
    end

    // Scan slot timing and which digit the next slot will show; the segment
    // pattern is looked up for that next digit so seg and dig_sel move together.
    assign scan_wrap = (scan_cnt == SCAN_LAST);

    always_comb begin
        dig_nxt = dig_r;
        if (scan_wrap) begin
            dig_nxt = (dig_r == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
        seg_digit = (dig_nxt == DIG_ONES) ? ones : tens;
    end

    bcd7seg u_bcd7seg (
        .bcd (seg_digit),
        .seg (seg_dec)
    );

    // Scan counter, digit enable and registered segment drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_r    <= DIG_ONES;
            seg      <= SEG_0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
            dig_r    <= dig_nxt;
            seg      <= seg_dec;
        end
    end

    assign dig_sel = dig_r;

endmodule

// File: tb/tb_counter24_bcd_scan.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// behavioural model of the counter and display scan.
module tb_counter24_bcd_scan;

    localparam int MOD      = 24;
    localparam int SCAN_DIV = 4;
    localparam int SCAN_W   = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick_in  = 1'b0;
    logic       run      = 1'b0;
    logic       up_dn    = 1'b1;
    logic       clr      = 1'b0;
    logic       load     = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [3:0] tens, ones;
    logic       carry, load_err;
    logic [7:0] seg;
    logic [1:0] dig_sel;

    counter24_bcd_scan #(.MOD(MOD), .SCAN_DIV(SCAN_DIV), .SCAN_W(SCAN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_in  (tick_in),
        .run      (run),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .tens     (tens),
        .ones     (ones),
        .carry    (carry),
        .load_err (load_err),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int carry_seen = 0;

    // Behavioural model: counter as a plain integer, scan as slot counter + phase.
    int  m_val = 0, m_carry = 0, m_lerr = 0, m_sc = 0, m_phase = 0, m_seg = 8'h3F;
    int  cyc = 0;
    int  due[$];
    bit  prev_ti = 1'b0, prev_vld = 1'b0;
    logic [7:0] SEG_TAB [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model across one rising clock edge using the inputs held there.
    task automatic model_step();
        int old_val;
        int tick_now;
        int lt, lo;
        old_val = m_val;
        cyc++;
        if (!rst_n) begin
            m_val = 0; m_carry = 0; m_lerr = 0; m_sc = 0; m_phase = 0; m_seg = 8'h3F;
            due.delete();
            prev_ti = 1'b0; prev_vld = 1'b0;
            return;
        end
        tick_now = 0;
        if (due.size() > 0 && due[0] == cyc) begin
            tick_now = 1;
            void'(due.pop_front());
        end
        // A rise seen at this edge takes effect two edges later (3rd edge after the rise).
        if (prev_vld && tick_in && !prev_ti) due.push_back(cyc + 2);
        prev_ti  = tick_in;
        prev_vld = 1'b1;

        if (m_sc == SCAN_DIV - 1) begin
            m_sc = 0;
            m_phase ^= 1;
        end else begin
            m_sc++;
        end
        m_seg = SEG_TAB[(m_phase == 0) ? (old_val % 10) : (old_val / 10)];

        m_carry = 0;
        m_lerr  = 0;
        if (clr) begin
            m_val = 0;
        end else if (load) begin
            lt = int'(load_val[7:4]);
            lo = int'(load_val[3:0]);
            if (lt <= 9 && lo <= 9 && (lt * 10 + lo) < MOD) m_val = lt * 10 + lo;
            else m_lerr = 1;
        end else if (tick_now == 1 && run) begin
            if (up_dn) begin
                if (m_val == MOD - 1) begin m_val = 0; m_carry = 1; end
                else m_val++;
            end else begin
                if (m_val == 0) begin m_val = MOD - 1; m_carry = 1; end
                else m_val--;
            end
        end
    endtask

    // One clock: wait for the falling edge, update the model, compare all outputs.
    task automatic step();
        @(negedge clk);
        model_step();
        if (carry === 1'b1) carry_seen++;
        check("tens",     int'(tens),     m_val / 10);
        check("ones",     int'(ones),     m_val % 10);
        check("carry",    int'(carry),    m_carry);
        check("load_err", int'(load_err), m_lerr);
        check("dig_sel",  int'(dig_sel),  (m_phase == 0) ? 2 : 1);
        check("seg",      int'(seg),      m_seg);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int hi, input int lo);
        tick_in = 1'b1;
        cycles(hi);
        tick_in = 1'b0;
        cycles(lo);
    endtask

    task automatic load_do(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        int hold;
        int last_chg;
        logic [1:0] prev_dig;

        // Reset and release
        cycles(3);
        check("rst_seg", int'(seg), 8'h3F);
        check("rst_dig", int'(dig_sel), 2'b10);
        rst_n = 1'b1;
        step();
        check("rel_val", int'({tens, ones}), 8'h00);

        // Up count: 24 long pulses, first one checks landing latency
        run = 1'b1;
        up_dn = 1'b1;
        tick_in = 1'b1;
        step();
        step();
        check("lat_hold", int'(ones), 0);
        step();
        check("lat_step", int'(ones), 1);
        cycles(47);
        tick_in = 1'b0;
        cycles(50);
        carry_seen = 0;
        for (int p = 1; p < 23; p++) pulse(50, 50);
        check("up_23", int'({tens, ones}), 8'h23);
        check("up_nocarry", carry_seen, 0);
        pulse(50, 50);
        check("up_wrap", int'({tens, ones}), 8'h00);
        check("up_carry_cnt", carry_seen, 1);

        // Down count and wrap
        up_dn = 1'b0;
        load_do(8'h01);
        check("ld_01", int'({tens, ones}), 8'h01);
        pulse(10, 10);
        check("dn_00", int'({tens, ones}), 8'h00);
        carry_seen = 0;
        pulse(10, 10);
        check("dn_wrap", int'({tens, ones}), 8'h23);
        check("dn_carry_cnt", carry_seen, 1);
        load_do(8'h10);
        pulse(10, 10);
        check("dn_borrow", int'({tens, ones}), 8'h09);

        // Load acceptance rules
        load_do(8'h24);
        check("ld24_err", int'(load_err), 1);
        check("ld24_hold", int'({tens, ones}), 8'h09);
        step();
        check("ld24_pulse", int'(load_err), 0);
        load_do(8'h1A);
        check("ld1A_err", int'(load_err), 1);
        check("ld1A_hold", int'({tens, ones}), 8'h09);
        step();
        load_do(8'h19);
        check("ld19", int'({tens, ones}), 8'h19);
        check("ld19_err", int'(load_err), 0);

        // Priority: clr + load + tick in one cycle
        up_dn = 1'b1;
        tick_in = 1'b1;
        step();
        step();
        clr = 1'b1; load = 1'b1; load_val = 8'h05;
        step();
        clr = 1'b0; load = 1'b0;
        check("prio_clr", int'({tens, ones}), 8'h00);
        tick_in = 1'b0;
        cycles(10);
        // load wins over a coincident tick
        tick_in = 1'b1;
        step();
        step();
        load_do(8'h12);
        check("prio_load", int'({tens, ones}), 8'h12);
        tick_in = 1'b0;
        cycles(10);
        // rejected load still swallows the tick
        tick_in = 1'b1;
        step();
        step();
        load_do(8'h30);
        check("prio_rej", int'({tens, ones}), 8'h12);
        tick_in = 1'b0;
        cycles(10);

        // run=0 discards ticks
        run = 1'b0;
        for (int p = 0; p < 5; p++) pulse(6, 6);
        check("run0_hold", int'({tens, ones}), 8'h12);
        run = 1'b1;
        pulse(6, 6);
        check("run1_step", int'({tens, ones}), 8'h13);

        // Random stimulus
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                tick_in = ~tick_in;
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            run   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            clr   = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 31) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                   : {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            step();
        end
        clr = 1'b0;
        load = 1'b0;
        tick_in = 1'b0;
        cycles(10);

        // Mid-count reset with a tick in flight, released with tick_in high
        load_do(8'h15);
        run = 1'b1;
        up_dn = 1'b1;
        tick_in = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_val", int'({tens, ones}), 8'h00);
        check("arst_dig", int'(dig_sel), 2'b10);
        check("arst_seg", int'(seg), 8'h3F);
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
        check("rel_hi_val", int'({tens, ones}), 8'h00);
        tick_in = 1'b0;
        cycles(5);

        // Display scan at value 17
        run = 1'b0;
        load_do(8'h17);
        step();
        prev_dig = dig_sel;
        last_chg = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dig_sel == 2'b10) check("scan_seg_ones", int'(seg), 8'h07);
            else check("scan_seg_tens", int'(seg), 8'h06);
            if (dig_sel != prev_dig) begin
                if (last_chg >= 0) check("scan_period", i - last_chg, 4);
                last_chg = i;
            end
            prev_dig = dig_sel;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
